// File: rtl/data_mem_lsu_pkg.sv
// Shared definitions for the data-memory load-store unit.
// Holds the FSM state encoding, the funct3 width codes, the response-timeout
// counter width and small width-decode helpers used by data_mem_lsu and
// data_mem_lsu_align.
package data_mem_lsu_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StReq   = 3'd1,
      StWait  = 3'd2,
      StReq2  = 3'd3,
      StWait2 = 3'd4,
      StDone  = 3'd5
   } lsu_state_e;

   // funct3 access width codes
   localparam logic [2:0] WidthB  = 3'b000;
   localparam logic [2:0] WidthH  = 3'b001;
   localparam logic [2:0] WidthW  = 3'b010;
   localparam logic [2:0] WidthD  = 3'b011;
   localparam logic [2:0] WidthBu = 3'b100;
   localparam logic [2:0] WidthHu = 3'b101;
   localparam logic [2:0] WidthWu = 3'b110;

   localparam int unsigned CntWidth = 8;

   // Number of bytes touched by an access; the low two funct3 bits encode the size.
   function automatic logic [3:0] width_bytes(input logic [2:0] width);
      logic [3:0] bytes;
      unique case (width[1:0])
         2'b00:   bytes = 4'd1;
         2'b01:   bytes = 4'd2;
         2'b10:   bytes = 4'd4;
         default: bytes = 4'd8;
      endcase
      return bytes;
   endfunction

   // D and WU only exist on 64-bit cores; 3'b111 is never a valid width.
   function automatic logic width_legal(input logic [2:0] width, input int unsigned xlen);
      logic ok;
      ok = (width != 3'b111);
      if (xlen != 64 && (width == WidthD || width == WidthWu)) begin
         ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/data_mem_lsu_align.sv
// Combinational byte-lane steering for the load-store unit.
// Ports:
//   offset     byte offset of the access inside a bus beat
//   width      funct3 width code
//   store_data LSB-justified store data
//   rdata_lo   read data of the first (low-address) beat
//   rdata_hi   read data of the second beat of a split access
//   legal      width code is supported at this XLEN
//   crosses    access runs past the end of the beat
//   wdata_lo/wdata_hi, strobe_lo/strobe_hi  lane-shifted store data and byte enables per beat
//   load_data  merged, aligned and sign/zero-extended load result
module data_mem_lsu_align
   import data_mem_lsu_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   localparam int unsigned NB = XLEN / 8,
   localparam int unsigned OW = $clog2(NB)
) (
   input  logic [OW-1:0]   offset,
   input  logic [2:0]      width,
   input  logic [XLEN-1:0] store_data,
   input  logic [XLEN-1:0] rdata_lo,
   input  logic [XLEN-1:0] rdata_hi,
   output logic            legal,
   output logic            crosses,
   output logic [XLEN-1:0] wdata_lo,
   output logic [XLEN-1:0] wdata_hi,
   output logic [NB-1:0]   strobe_lo,
   output logic [NB-1:0]   strobe_hi,
   output logic [XLEN-1:0] load_data
);

   logic [3:0]        size;
   logic [4:0]        end_byte;
   logic [NB-1:0]     byte_mask;
   logic [XLEN-1:0]   data_mask;
   logic [2*XLEN-1:0] store_wide;
   logic [2*NB-1:0]   strobe_wide;
   logic [XLEN-1:0]   field;
   logic              sign;
   logic              fill;

   assign size     = width_bytes(width);
   assign legal    = width_legal(width, XLEN);
   assign end_byte = 5'(offset) + 5'(size);
   assign crosses  = end_byte > 5'(NB);

   always_comb begin
      byte_mask = '0;
      data_mask = '0;
      for (int i = 0; i < int'(NB); i++) begin
         byte_mask[i]       = (i < int'(size));
         data_mask[i*8 +: 8] = {8{byte_mask[i]}};
      end
   end

   // Shifting into a double-width vector yields both beats of a split access at once:
   // the low half is the first beat, the spill-over is the second.
   assign store_wide  = {{XLEN{1'b0}}, store_data & data_mask} << {offset, 3'b000};
   assign strobe_wide = {{NB{1'b0}}, byte_mask} << offset;
   assign wdata_lo    = store_wide[XLEN-1:0];
   assign wdata_hi    = store_wide[2*XLEN-1:XLEN];
   assign strobe_lo   = strobe_wide[NB-1:0];
   assign strobe_hi   = strobe_wide[2*NB-1:NB];

   assign field = XLEN'({rdata_hi, rdata_lo} >> {offset, 3'b000});

   always_comb begin
      unique case (width[1:0])
         2'b00:   sign = field[7];
         2'b01:   sign = field[15];
         2'b10:   sign = field[31];
         default: sign = field[XLEN-1];
      endcase
   end

   // funct3[2] marks the unsigned variants
   assign fill = sign & ~width[2];

   always_comb begin
      load_data = '0;
      for (int i = 0; i < int'(NB); i++) begin
         load_data[i*8 +: 8] = (i < int'(size)) ? field[i*8 +: 8] : {8{fill}};
      end
   end

endmodule

// File: rtl/data_mem_lsu.sv
// Load-store unit between the core data port and a valid/ready memory bus.
// Stalls the core while one bus transaction (or two, for a split access) runs,
// then presents the extended load data and a fault flag for one DONE cycle.
// Optional feature macro: MISALIGNED_SPLIT_EN -- when defined, an access that
// crosses a bus-beat boundary is issued as two beats; when undefined it faults
// without bus traffic.
// Ports:
//   clock, reset (async, active-low)
//   core_address, core_write_data, core_width, core_read_enable, core_write_enable
//   core_data_fetched, core_stall, core_fault
//   bus_req_valid/ready, bus_req_write, bus_req_address, bus_req_wdata, bus_req_strobe
//   bus_resp_valid, bus_resp_rdata, bus_resp_error
module data_mem_lsu
   import data_mem_lsu_pkg::*;
#(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   localparam int unsigned NB = XLEN / 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] core_address,
   input  logic [XLEN-1:0]       core_write_data,
   input  logic [2:0]            core_width,
   input  logic                  core_read_enable,
   input  logic                  core_write_enable,
   output logic [XLEN-1:0]       core_data_fetched,
   output logic                  core_stall,
   output logic                  core_fault,
   output logic                  bus_req_valid,
   input  logic                  bus_req_ready,
   output logic                  bus_req_write,
   output logic [ADDR_WIDTH-1:0] bus_req_address,
   output logic [XLEN-1:0]       bus_req_wdata,
   output logic [NB-1:0]         bus_req_strobe,
   input  logic                  bus_resp_valid,
   input  logic [XLEN-1:0]       bus_resp_rdata,
   input  logic                  bus_resp_error
);

   localparam int unsigned OW = $clog2(NB);
   localparam int unsigned AH = ADDR_WIDTH - OW;
   localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TIMEOUT_CYCLES - 1);

   lsu_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]            width_q, width_d;
   logic [XLEN-1:0]       sdata_q, sdata_d;
   logic                  write_q, write_d;
   logic                  fault_q, fault_d;
   logic [XLEN-1:0]       rdata0_q, rdata0_d;
   logic [XLEN-1:0]       rdata1_q, rdata1_d;
   logic [CntWidth-1:0]   count_q, count_d;
`ifdef MISALIGNED_SPLIT_EN
   logic                  split_q, split_d;
`endif

   logic                  access;
   logic                  reject;
   logic [OW-1:0]         align_offset;
   logic [2:0]            align_width;
   logic                  legal;
   logic                  crosses;
   logic [XLEN-1:0]       wdata_lo, wdata_hi;
   logic [NB-1:0]         strobe_lo, strobe_hi;
   logic [XLEN-1:0]       load_data;
   logic                  in_req;
   logic                  hi_beat;
   logic [AH-1:0]         beat_base;

   assign access = core_read_enable | core_write_enable;

   // In IDLE the legality/crossing decision is made on the live core inputs;
   // afterwards the latched access drives the lane steering.
   assign align_offset = (state_q == StIdle) ? core_address[OW-1:0] : addr_q[OW-1:0];
   assign align_width  = (state_q == StIdle) ? core_width : width_q;

   data_mem_lsu_align #(
      .XLEN(XLEN)
   ) u_align (
      .offset    (align_offset),
      .width     (align_width),
      .store_data(sdata_q),
      .rdata_lo  (rdata0_q),
      .rdata_hi  (rdata1_q),
      .legal     (legal),
      .crosses   (crosses),
      .wdata_lo  (wdata_lo),
      .wdata_hi  (wdata_hi),
      .strobe_lo (strobe_lo),
      .strobe_hi (strobe_hi),
      .load_data (load_data)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      width_d  = width_q;
      sdata_d  = sdata_q;
      write_d  = write_q;
      fault_d  = fault_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      count_d  = count_q;
`ifdef MISALIGNED_SPLIT_EN
      split_d  = split_q;
      reject   = ~legal;
`else
      reject   = ~legal | crosses;
`endif

      unique case (state_q)
         StIdle: begin
            if (access) begin
               addr_d   = core_address;
               width_d  = core_width;
               sdata_d  = core_write_data;
               write_d  = core_write_enable;
               rdata0_d = '0;
               rdata1_d = '0;
`ifdef MISALIGNED_SPLIT_EN
               split_d  = crosses;
`endif
               fault_d  = reject;
               state_d  = reject ? StDone : StReq;
            end
         end
         StReq: begin
            if (bus_req_ready) begin
               count_d = '0;
               state_d = StWait;
            end
         end
         StWait: begin
            if (bus_resp_valid) begin
               rdata0_d = bus_resp_rdata;
               if (bus_resp_error) begin
                  fault_d = 1'b1;
                  state_d = StDone;
               end else begin
`ifdef MISALIGNED_SPLIT_EN
                  state_d = split_q ? StReq2 : StDone;
`else
                  state_d = StDone;
`endif
               end
            end else if (count_q == TimeoutLast) begin
               fault_d = 1'b1;
               state_d = StDone;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
`ifdef MISALIGNED_SPLIT_EN
         StReq2: begin
            if (bus_req_ready) begin
               count_d = '0;
               state_d = StWait2;
            end
         end
         StWait2: begin
            if (bus_resp_valid) begin
               rdata1_d = bus_resp_rdata;
               fault_d  = bus_resp_error;
               state_d  = StDone;
            end else if (count_q == TimeoutLast) begin
               fault_d = 1'b1;
               state_d = StDone;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
`endif
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         width_q  <= '0;
         sdata_q  <= '0;
         write_q  <= 1'b0;
         fault_q  <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         width_q  <= width_d;
         sdata_q  <= sdata_d;
         write_q  <= write_d;
         fault_q  <= fault_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         count_q  <= count_d;
      end
   end

`ifdef MISALIGNED_SPLIT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         split_q <= 1'b0;
      end else begin
         split_q <= split_d;
      end
   end
`endif

   // Bus fields are gated by the request states so they read zero at and after reset,
   // and valid drops as soon as the asynchronous reset forces IDLE.
   assign in_req    = (state_q == StReq) || (state_q == StReq2);
   assign hi_beat   = (state_q == StReq2);
   assign beat_base = addr_q[ADDR_WIDTH-1:OW] + AH'(hi_beat);

   assign bus_req_valid   = in_req;
   assign bus_req_write   = in_req & write_q;
   assign bus_req_address = in_req ? {beat_base, {OW{1'b0}}} : '0;
   assign bus_req_wdata   = (in_req & write_q) ? (hi_beat ? wdata_hi : wdata_lo) : '0;
   assign bus_req_strobe  = in_req ? (hi_beat ? strobe_hi : strobe_lo) : '0;

   assign core_stall        = access & (state_q != StDone);
   assign core_fault        = (state_q == StDone) & fault_q;
   assign core_data_fetched = ((state_q == StDone) && !write_q && !fault_q) ? load_data : '0;

endmodule

// File: tb/tb_data_mem_lsu.sv
module tb_data_mem_lsu;
   import data_mem_lsu_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] core_address;
   logic [31:0] core_write_data;
   logic [2:0]  core_width;
   logic        core_read_enable;
   logic        core_write_enable;
   logic [31:0] core_data_fetched;
   logic        core_stall;
   logic        core_fault;
   logic        bus_req_valid;
   logic        bus_req_ready;
   logic        bus_req_write;
   logic [31:0] bus_req_address;
   logic [31:0] bus_req_wdata;
   logic [3:0]  bus_req_strobe;
   logic        bus_resp_valid;
   logic [31:0] bus_resp_rdata;
   logic        bus_resp_error;

   always #5 clock = ~clock;

   data_mem_lsu #(
      .XLEN(32),
      .ADDR_WIDTH(32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .core_address     (core_address),
      .core_write_data  (core_write_data),
      .core_width       (core_width),
      .core_read_enable (core_read_enable),
      .core_write_enable(core_write_enable),
      .core_data_fetched(core_data_fetched),
      .core_stall       (core_stall),
      .core_fault       (core_fault),
      .bus_req_valid    (bus_req_valid),
      .bus_req_ready    (bus_req_ready),
      .bus_req_write    (bus_req_write),
      .bus_req_address  (bus_req_address),
      .bus_req_wdata    (bus_req_wdata),
      .bus_req_strobe   (bus_req_strobe),
      .bus_resp_valid   (bus_resp_valid),
      .bus_resp_rdata   (bus_resp_rdata),
      .bus_resp_error   (bus_resp_error)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strobe;
      logic        write;
   } bus_exp_t;

   typedef struct {
      logic [31:0] data;
      logic        fault;
      int          stall;
   } rsp_exp_t;

   bus_exp_t    bus_q[$];
   rsp_exp_t    rsp_q[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] mem [logic [31:0]];
   int          cfg_ready_delay = 0;
   int          cfg_resp_delay = 0;
   logic        cfg_err = 1'b0;
   int          stall_cnt = 0;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   task automatic exp_bus(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strobe, input logic write);
      bus_q.push_back('{addr: addr, wdata: wdata, strobe: strobe, write: write});
   endtask

   task automatic exp_rsp(input logic [31:0] data, input logic fault, input int stall);
      rsp_q.push_back('{data: data, fault: fault, stall: stall});
   endtask

   // Issue one core access and hold it until the stall drops (bounded).
   task automatic access(input logic rd, input logic [31:0] addr, input logic [2:0] w,
                         input logic [31:0] wd);
      int n;
      core_address      = addr;
      core_width        = w;
      core_write_data   = wd;
      core_read_enable  = rd;
      core_write_enable = ~rd;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (core_stall && n < 60);
      if (core_stall) begin
         total++;
         bad++;
         $display("FAIL stall_bound: got stall after %0d cycles expected release", n);
      end
      @(posedge clock);
      #1;
      core_read_enable  = 1'b0;
      core_write_enable = 1'b0;
   endtask

   // Bus slave: configurable ready and response latency, reads from mem.
   initial begin : responder
      logic [31:0] acc_addr;
      bus_req_ready  = 1'b0;
      bus_resp_valid = 1'b0;
      bus_resp_rdata = '0;
      bus_resp_error = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         bus_resp_valid = 1'b0;
         bus_resp_error = 1'b0;
         bus_resp_rdata = '0;
         if (reset && bus_req_valid) begin
            for (int i = 0; i < cfg_ready_delay; i++) begin
               @(posedge clock);
               #1;
            end
            acc_addr      = bus_req_address;
            bus_req_ready = 1'b1;
            @(posedge clock);
            #1;
            bus_req_ready = 1'b0;
            for (int i = 0; i < cfg_resp_delay; i++) begin
               @(posedge clock);
               #1;
            end
            bus_resp_valid = 1'b1;
            bus_resp_error = cfg_err;
            bus_resp_rdata = mem.exists(acc_addr) ? mem[acc_addr] : 32'h0;
         end
      end
   end

   // Bus request monitor: every valid cycle must match the head expectation.
   initial begin : bus_mon
      forever begin
         @(negedge clock);
         if (reset && bus_req_valid) begin
            if (bus_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL bus_unexpected: got request at %0h expected no request",
                        bus_req_address);
            end else begin
               check("bus_addr", bus_req_address, bus_q[0].addr);
               check("bus_wdata", bus_req_wdata, bus_q[0].wdata);
               check("bus_strobe", bus_req_strobe, bus_q[0].strobe);
               check("bus_write", bus_req_write, bus_q[0].write);
               if (bus_req_ready) void'(bus_q.pop_front());
            end
         end
      end
   end

   // Core response monitor: counts stall cycles, checks the DONE cycle.
   initial begin : rsp_mon
      rsp_exp_t e;
      forever begin
         @(negedge clock);
         if (reset && (core_read_enable || core_write_enable)) begin
            if (core_stall) begin
               stall_cnt++;
            end else begin
               if (rsp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL rsp_unexpected: got completion data %0h expected none",
                           core_data_fetched);
               end else begin
                  e = rsp_q.pop_front();
                  check("rsp_data", core_data_fetched, e.data);
                  check("rsp_fault", core_fault, e.fault);
                  check("rsp_stall", stall_cnt, e.stall);
               end
               stall_cnt = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

   initial begin : main
      reset             = 1'b0;
      core_address      = '0;
      core_write_data   = '0;
      core_width        = '0;
      core_read_enable  = 1'b0;
      core_write_enable = 1'b0;
      mem[32'h100] = 32'h4433_2211;
      mem[32'h104] = 32'h8000_00F0;
      mem[32'h200] = 32'hFF00_0000;
      mem[32'h204] = 32'h9ABC_0000;

      repeat (2) @(negedge clock);
      check("rst_valid", bus_req_valid, 1'b0);
      check("rst_write", bus_req_write, 1'b0);
      check("rst_addr", bus_req_address, 32'h0);
      check("rst_wdata", bus_req_wdata, 32'h0);
      check("rst_strobe", bus_req_strobe, 4'h0);
      check("rst_data", core_data_fetched, 32'h0);
      check("rst_fault", core_fault, 1'b0);
      check("rst_stall", core_stall, 1'b0);
      @(posedge clock);
      #3;
      reset = 1'b1;
      @(posedge clock);
      #1;

      // Aligned word load, minimum latency
      exp_bus(32'h104, 32'h0, 4'b1111, 1'b0);
      exp_rsp(32'h8000_00F0, 1'b0, 3);
      access(1'b1, 32'h104, WidthW, 32'h0);

      // Byte store to lane 3, then signed/unsigned byte loads
      exp_bus(32'h200, 32'hAB00_0000, 4'b1000, 1'b1);
      exp_rsp(32'h0, 1'b0, 3);
      access(1'b0, 32'h203, WidthB, 32'h0000_00AB);
      exp_bus(32'h200, 32'h0, 4'b1000, 1'b0);
      exp_rsp(32'hFFFF_FFFF, 1'b0, 3);
      access(1'b1, 32'h203, WidthB, 32'h0);
      exp_bus(32'h200, 32'h0, 4'b1000, 1'b0);
      exp_rsp(32'h0000_00FF, 1'b0, 3);
      access(1'b1, 32'h203, WidthBu, 32'h0);

      // Store data outside the field must be masked off
      exp_bus(32'h000, 32'h0000_AB00, 4'b0010, 1'b1);
      exp_rsp(32'h0, 1'b0, 3);
      access(1'b0, 32'h001, WidthB, 32'h1234_56AB);
      exp_bus(32'h108, 32'hBEEF_0000, 4'b1100, 1'b1);
      exp_rsp(32'h0, 1'b0, 3);
      access(1'b0, 32'h10A, WidthH, 32'h1234_BEEF);

      // Halfword loads: sign, zero, and an in-beat odd offset
      exp_bus(32'h204, 32'h0, 4'b1100, 1'b0);
      exp_rsp(32'hFFFF_9ABC, 1'b0, 3);
      access(1'b1, 32'h206, WidthH, 32'h0);
      exp_bus(32'h204, 32'h0, 4'b1100, 1'b0);
      exp_rsp(32'h0000_9ABC, 1'b0, 3);
      access(1'b1, 32'h206, WidthHu, 32'h0);
      exp_bus(32'h100, 32'h0, 4'b0110, 1'b0);
      exp_rsp(32'h0000_3322, 1'b0, 3);
      access(1'b1, 32'h101, WidthH, 32'h0);

      // Wait states: ready 3 late, response 2 late -> 3+3+2 stall cycles
      cfg_ready_delay = 3;
      cfg_resp_delay  = 2;
      exp_bus(32'h100, 32'h0, 4'b1111, 1'b0);
      exp_rsp(32'h4433_2211, 1'b0, 8);
      access(1'b1, 32'h100, WidthW, 32'h0);
      cfg_ready_delay = 0;
      cfg_resp_delay  = 0;

      // Bus error: single-cycle fault pulse, then a clean access
      mem[32'h104] = 32'h8877_6655;
      cfg_err = 1'b1;
      exp_bus(32'h104, 32'h0, 4'b1111, 1'b0);
      exp_rsp(32'h0, 1'b1, 3);
      access(1'b1, 32'h104, WidthW, 32'h0);
      cfg_err = 1'b0;
      @(negedge clock);
      check("fault_pulse", core_fault, 1'b0);
      @(posedge clock);
      #1;
      exp_bus(32'h104, 32'h0, 4'b1111, 1'b0);
      exp_rsp(32'h8877_6655, 1'b0, 3);
      access(1'b1, 32'h104, WidthW, 32'h0);

      // Timeout after 4 WAIT cycles; the late response lands in IDLE
      cfg_resp_delay = 5;
      exp_bus(32'h100, 32'h0, 4'b1111, 1'b0);
      exp_rsp(32'h0, 1'b1, 6);
      access(1'b1, 32'h100, WidthW, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("late_fault", core_fault, 1'b0);
         check("late_valid", bus_req_valid, 1'b0);
      end
      cfg_resp_delay = 0;
      @(posedge clock);
      #1;
      exp_bus(32'h100, 32'h0, 4'b1111, 1'b0);
      exp_rsp(32'h4433_2211, 1'b0, 3);
      access(1'b1, 32'h100, WidthW, 32'h0);

      // Misaligned word and halfword loads crossing the beat boundary
`ifdef MISALIGNED_SPLIT_EN
      exp_bus(32'h100, 32'h0, 4'b1100, 1'b0);
      exp_bus(32'h104, 32'h0, 4'b0011, 1'b0);
      exp_rsp(32'h6655_4433, 1'b0, 5);
      access(1'b1, 32'h102, WidthW, 32'h0);
      exp_bus(32'h100, 32'h0, 4'b1000, 1'b0);
      exp_bus(32'h104, 32'h0, 4'b0001, 1'b0);
      exp_rsp(32'h0000_5544, 1'b0, 5);
      access(1'b1, 32'h103, WidthH, 32'h0);
`else
      exp_rsp(32'h0, 1'b1, 1);
      access(1'b1, 32'h102, WidthW, 32'h0);
      exp_rsp(32'h0, 1'b1, 1);
      access(1'b1, 32'h103, WidthH, 32'h0);
`endif

      // Widths that do not exist on a 32-bit core
      exp_rsp(32'h0, 1'b1, 1);
      access(1'b1, 32'h100, WidthD, 32'h0);
      exp_rsp(32'h0, 1'b1, 1);
      access(1'b1, 32'h100, WidthWu, 32'h0);
      exp_rsp(32'h0, 1'b1, 1);
      access(1'b0, 32'h100, 3'b111, 32'h5555_5555);

      repeat (3) @(negedge clock);
      check("bus_q_empty", bus_q.size(), 0);
      check("rsp_q_empty", rsp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
